// File: rtl/ps2_pkg.sv
// Shared PS/2 constants and types for the scan decoder and the keyboard interpreter.
// Holds prefix bytes, device-reply codes, interpreter key codes and the frame FSM state enum.
package ps2_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

    localparam int         PS2_NUM_REPLIES = 6;
    localparam logic [7:0] PS2_REPLY_CODES [PS2_NUM_REPLIES] =
        '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    // Self-test results, acks and resend requests are not key events.
    function automatic logic is_device_reply(input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < PS2_NUM_REPLIES; i++) begin
            if (code == PS2_REPLY_CODES[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, clock glitch filter, 11-bit frame FSM and
// inter-edge timeout. Emits one byte_ready pulse per good frame or one frame_error pulse.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_byte_ready,
    output logic [7:0] o_byte,
    output logic       o_frame_error,
    output rx_state_t  o_state
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_data_sync;
    logic [FW-1:0] r_filt_cnt;
    logic          r_clk_filt;
    logic          r_fe;

    rx_state_t     r_state;
    rx_state_t     w_state_nxt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic [TW-1:0] r_timer;
    logic          r_byte_ready;
    logic          r_frame_error;

    logic          w_data;
    logic          w_timeout;
    logic          w_ready_nxt;
    logic          w_err_nxt;

    assign w_data = r_data_sync[1];

    // The filtered clock rests high (bus idle) so reset never manufactures a falling edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clk_sync  <= 2'b00;
            r_data_sync <= 2'b00;
            r_filt_cnt  <= '0;
            r_clk_filt  <= 1'b1;
            r_fe        <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
            r_fe        <= 1'b0;
            if (r_clk_sync[1] == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FILT_LAST) begin
                r_clk_filt <= r_clk_sync[1];
                r_filt_cnt <= '0;
                r_fe       <= ~r_clk_sync[1];
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    assign w_timeout = (r_state != RX_IDLE) && !r_fe && (r_timer == TO_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_ready_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (r_fe && !w_data) begin
                    w_state_nxt = RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_fe && (r_bit_cnt == 3'd7)) begin
                    w_state_nxt = RX_PARITY;
                end
            end
            RX_PARITY: begin
                if (r_fe) begin
                    w_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (r_fe) begin
                    w_state_nxt = RX_IDLE;
                    if (w_data && ((^r_shift) ^ r_parity)) begin
                        w_ready_nxt = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = RX_IDLE;
        endcase
        if (w_timeout) begin
            w_state_nxt = RX_IDLE;
            w_err_nxt   = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= RX_IDLE;
            r_bit_cnt     <= 3'd0;
            r_shift       <= 8'h00;
            r_parity      <= 1'b0;
            r_timer       <= '0;
            r_byte_ready  <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_byte_ready  <= w_ready_nxt;
            r_frame_error <= w_err_nxt;
            if (r_state == RX_IDLE || r_fe) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
            // Data arrives LSB first, so shift in from the top.
            if (r_fe) begin
                case (r_state)
                    RX_IDLE:   r_bit_cnt <= 3'd0;
                    RX_DATA: begin
                        r_shift   <= {w_data, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    RX_PARITY: r_parity <= w_data;
                    default:   r_bit_cnt <= 3'd0;
                endcase
            end
        end
    end

    assign o_byte_ready  = r_byte_ready;
    assign o_byte        = r_shift;
    assign o_frame_error = r_frame_error;
    assign o_state       = r_state;

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 scan decoder: receives frames and folds E0/F0 prefixes into one key event per code.
// Device replies are swallowed; any frame error drops pending prefixes.
module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       valid,
    output logic       makeBreak,
    output logic [7:0] outCode,
    output logic       extended,
    output logic       frame_error,
    output logic [1:0] dbg_state
);

    logic       w_byte_ready;
    logic [7:0] w_byte;
    logic       w_frame_error;
    rx_state_t  w_rx_state;

    logic       r_ext_flag;
    logic       r_brk_flag;
    logic       r_valid;
    logic       r_make_break;
    logic [7:0] r_out_code;
    logic       r_extended;

    ps2_frame_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .o_byte_ready (w_byte_ready),
        .o_byte       (w_byte),
        .o_frame_error(w_frame_error),
        .o_state      (w_rx_state)
    );

    // Output contract: valid is a one-cycle pulse with no ready/backpressure; outCode,
    // makeBreak and extended are updated in that cycle and held until the next valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ext_flag   <= 1'b0;
            r_brk_flag   <= 1'b0;
            r_valid      <= 1'b0;
            r_make_break <= 1'b0;
            r_out_code   <= 8'h00;
            r_extended   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_frame_error) begin
                r_ext_flag <= 1'b0;
                r_brk_flag <= 1'b0;
            end else if (w_byte_ready) begin
                if (w_byte == PS2_PREFIX_EXT) begin
                    r_ext_flag <= 1'b1;
                end else if (w_byte == PS2_PREFIX_BREAK) begin
                    r_brk_flag <= 1'b1;
                end else if (is_device_reply(w_byte)) begin
                    r_ext_flag <= 1'b0;
                    r_brk_flag <= 1'b0;
                end else begin
                    r_valid      <= 1'b1;
                    r_out_code   <= w_byte;
                    r_make_break <= ~r_brk_flag;
                    r_extended   <= r_ext_flag;
                    r_ext_flag   <= 1'b0;
                    r_brk_flag   <= 1'b0;
                end
            end
        end
    end

    assign valid       = r_valid;
    assign makeBreak   = r_make_break;
    assign outCode     = r_out_code;
    assign extended    = r_extended;
    assign frame_error = w_frame_error;
    assign dbg_state   = w_rx_state;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder: drives PS/2 pin waveforms and scores each
// valid / frame_error pulse against an expected-event queue.
module tb_ps2_scan_decoder;

    localparam int W        = 11;    // {is_error, makeBreak, extended, code}
    localparam int HALF     = 30;    // clk cycles per PS/2 clock half period
    localparam int TIMEOUT  = 5000;
    localparam int PIPE_LAT = 12;    // pin edge -> valid: 2 sync + 8 filter samples + fe, byte_ready, valid

    logic       clk;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       valid;
    logic       makeBreak;
    logic [7:0] outCode;
    logic       extended;
    logic       frame_error;
    logic [1:0] dbg_state;

    logic [W-1:0] exp_q[$];
    int total;
    int bad;
    int cyc;
    int stop_cyc;
    int last_valid_cyc;
    logic prev_valid;
    logic prev_err;

    ps2_scan_decoder #(
        .FILTER_LEN    (8),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .valid      (valid),
        .makeBreak  (makeBreak),
        .outCode    (outCode),
        .extended   (extended),
        .frame_error(frame_error),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: run did not finish, %0d events still expected", exp_q.size());
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_clks(HALF);
        ps2_clk  = 1'b0;
        stop_cyc = cyc;
        wait_clks(HALF);
        ps2_clk  = 1'b1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par_ok);
        logic par;
        par = ~(^d);
        if (!par_ok) par = ~par;
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int first, input int last);
        for (int i = first; i <= last; i++) send_bit(f[i]);
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d);
        send_bits(mk_frame(d, 1'b1), 0, 10);
        wait_clks(40);
    endtask

    task automatic push_key(input logic [7:0] code, input logic mb, input logic ext);
        exp_q.push_back({1'b0, mb, ext, code});
    endtask

    task automatic push_err();
        exp_q.push_back({1'b1, 10'b0});
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        prev_valid     = 1'b0;
        prev_err       = 1'b0;
        last_valid_cyc = -1;
    end

    always @(negedge clk) begin
        logic [W-1:0] got;
        logic [W-1:0] exp;
        if (!reset && (valid || frame_error)) begin
            got = {frame_error, valid ? {makeBreak, extended, outCode} : 10'b0};
            total++;
            if (valid && frame_error) begin
                bad++;
                $display("FAIL both_pulses: valid=%0b frame_error=%0b expected one at a time", valid, frame_error);
            end
            total++;
            if ((valid && prev_valid) || (frame_error && prev_err)) begin
                bad++;
                $display("FAIL pulse_width: pulse high two cycles running at cycle %0d", cyc);
            end
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: got %h with nothing expected", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    bad++;
                    $display("FAIL event: got {err,mb,ext,code}=%h expected %h", got, exp);
                end
            end
            if (valid) last_valid_cyc = cyc;
        end
        prev_valid = valid;
        prev_err   = frame_error;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [10:0] f;
        total    = 0;
        bad      = 0;
        stop_cyc = 0;
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_clks(5);
        reset = 1'b0;
        wait_clks(2);
        check("reset_outputs", {valid, makeBreak, outCode, extended, frame_error}, 32'h0);
        check("reset_state", dbg_state, 32'h0);
        wait_clks(20);

        // Plain make code, with exact stop-edge to valid latency.
        push_key(8'h5A, 1'b1, 1'b0);
        send_frame(8'h5A);
        check("latency_5A", last_valid_cyc - stop_cyc, PIPE_LAT);

        // Break of a normal key.
        push_key(8'h5A, 1'b0, 1'b0);
        send_frame(8'hF0);
        send_frame(8'h5A);

        // Extended make, then extended break.
        push_key(8'h74, 1'b1, 1'b1);
        send_frame(8'hE0);
        send_frame(8'h74);
        push_key(8'h74, 1'b0, 1'b1);
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h74);

        // Parity error clears the pending E0.
        push_err();
        push_key(8'h74, 1'b1, 1'b0);
        send_frame(8'hE0);
        send_bits(mk_frame(8'h5A, 1'b0), 0, 10);
        wait_clks(40);
        send_frame(8'h74);

        // Timeout after 5 bits, then recovery.
        push_err();
        send_bits(mk_frame(8'h33, 1'b1), 0, 4);
        wait_clks(TIMEOUT + 100);
        check("timeout_idle", dbg_state, 32'h0);
        push_key(8'h6B, 1'b1, 1'b0);
        send_frame(8'h6B);

        // Short low glitch on ps2_clk in mid-frame must not shift a bit.
        push_key(8'h75, 1'b1, 1'b0);
        f = mk_frame(8'h75, 1'b1);
        send_bits(f, 0, 3);
        wait_clks(10);
        ps2_clk = 1'b0;
        wait_clks(3);
        ps2_clk = 1'b1;
        wait_clks(10);
        send_bits(f, 4, 10);
        wait_clks(40);

        // Device reply is swallowed and clears a pending E0.
        push_key(8'h72, 1'b1, 1'b0);
        send_frame(8'hE0);
        send_frame(8'hAA);
        send_frame(8'h72);

        // Reset after 4 bits; remaining bits (all ones) must be ignored.
        f = mk_frame(8'hF9, 1'b1);
        send_bits(f, 0, 3);
        reset = 1'b1;
        wait_clks(4);
        reset = 1'b0;
        wait_clks(2);
        check("midreset_state", dbg_state, 32'h0);
        wait_clks(5);
        send_bits(f, 4, 10);
        wait_clks(100);
        push_key(8'h5A, 1'b1, 1'b0);
        send_frame(8'h5A);

        wait_clks(200);
        check("queue_drained", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_scan_decoder.md
Name: ps2_scan_decoder

Overview:
- Upstream stage of the keyboard interpreter.
- Receives raw PS/2 frames from the keyboard pins, checks framing and parity, and strips the E0 (extended) and F0 (break) prefixes.
- Emits one single-cycle `valid` pulse per completed key event, with `outCode`, `makeBreak` and `extended`, all synchronous to `clk`.
- Feeds the interpreter directly: enter 5A, arrows 74/6B/75/72.

Parameters:
- FILTER_LEN, 8: consecutive equal `clk` samples required before the filtered `ps2_clk` changes level.
- TIMEOUT_CYCLES, 5000: maximum `clk` cycles between falling edges inside a frame (100 us at 50 MHz).

Ports:
- clk  in  1  system clock, single clock domain.
- reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data  in  1  raw PS/2 data pin, asynchronous.
- valid  out  1  one-cycle pulse: new key event.
- makeBreak  out  1  1 = make (press), 0 = break (release); held until next `valid`.
- outCode  out  8  scan code with prefixes removed; held until next `valid`.
- extended  out  1  1 if the event carried an E0 prefix; held until next `valid`.
- frame_error  out  1  one-cycle pulse on parity, stop or timeout failure.

Behaviour:
- Reset:
  - All outputs 0.
  - FSM in IDLE; prefix flags clear; synchronisers, filter and timeout counter cleared.
  - Reset asserted mid-frame discards the partial frame.
  - Bits arriving after reset release that are not preceded by a valid start bit are ignored.
- Input conditioning:
  - `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser.
  - Filtered clock: a saturating counter changes level only after FILTER_LEN identical samples; shorter glitches are ignored.
  - A falling edge of the filtered clock is a one-cycle strobe, `fe`.
  - Data is sampled on the `fe` cycle.
- Frame format: start 0, 8 data bits LSB first, odd parity, stop 1 (11 bits).
- Frame FSM:
  - IDLE: on `fe` with data=0 → DATA (bit counter = 0). On `fe` with data=1 → stay in IDLE, no error.
  - DATA: shift on each `fe`; after the 8th bit → PARITY.
  - PARITY: on `fe`, capture the parity bit → STOP.
  - STOP: on `fe`, if the stop bit is 1 and XOR(data, parity) = 1, raise internal `byte_ready` for one cycle the next cycle. Otherwise pulse `frame_error`. Either way → IDLE.
  - Timeout: in any non-IDLE state, if TIMEOUT_CYCLES elapse with no `fe`, pulse `frame_error` and go to IDLE. The counter reloads on every `fe`.
- Decoder, on `byte_ready`:
  - E0 → set ext_flag, no output.
  - F0 → set brk_flag, no output.
  - AA, FA, EE, FE, 00, FF (device replies) → no output, flags cleared.
  - Any other byte → next cycle: `valid`=1, `outCode`=byte, `makeBreak`=~brk_flag, `extended`=ext_flag. Both flags then cleared.
- Any `frame_error` clears both prefix flags.
- Latency: stop-bit `fe` at cycle N → `byte_ready` at N+1 → `valid` at N+2. `frame_error` is asserted at N+1.
- `valid` and `frame_error` are never high in the same cycle and never high for more than one cycle.
- No backpressure: the consumer must accept each pulse. The minimum spacing between pulses is one PS/2 frame.

Decomposition:
- Shared package ps2_pkg:
  - Constants PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_BREAK=8'hF0.
  - The device-reply code list.
  - Key codes KEY_ENTER=8'h5A, KEY_RIGHT=8'h74, KEY_LEFT=8'h6B, KEY_UP=8'h75, KEY_DOWN=8'h72, shared with the interpreter.
  - Frame FSM state enum.
- Sub-module ps2_frame_rx: synchronisers, glitch filter, frame FSM and timeout. Outputs `byte_ready`, `byte`, `frame_error`.
- The top level adds the prefix/decoder logic.

Test Plan:
- Frame 5A with parity bit 1 → exactly one `valid` at stop-edge+2; `outCode`=5A, `makeBreak`=1, `extended`=0; no `frame_error`.
- Frames F0, 5A → no pulse after F0; one `valid` with `outCode`=5A, `makeBreak`=0, `extended`=0.
- Frames E0, 74 → `valid`, `outCode`=74, `extended`=1, `makeBreak`=1. Then E0, F0, 74 → `outCode`=74, `extended`=1, `makeBreak`=0.
- Sequence E0, then a 5A frame with parity bit 0, then 74:
  - The bad frame gives a single `frame_error` and no `valid`.
  - 74 then decodes with `extended`=0 (flag cleared).
- 5 bits of a frame, then `ps2_clk` held high for TIMEOUT_CYCLES+1 → `frame_error` pulse, FSM in IDLE. Next good frame 6B → `valid`, `outCode`=6B.
- Case 6a: a 3-cycle low glitch on `ps2_clk` produces no bit shift.
- Case 6b: frame AA produces no `valid`.
- Case 6c: reset asserted after 4 bits, with the remaining bits then clocked → no `valid`, no `frame_error`.
